matbi_alarm_ctrl: RTL and testbench
===================================

Name: matbi_alarm_ctrl

Overview:
Alarm controller fed directly by the watch counter outputs (sec/min/hour). It holds a programmable alarm time and arms against live time. It raises a ring output on the exact minute boundary and supports stop, bounded snooze and auto-timeout. It is purely a consumer of the time values and detects second boundaries itself from changes on i_sec.

Parameters:
P_SEC_BIT, 6, width of i_sec
P_MIN_BIT, 6, width of i_min / alarm minute
P_HOUR_BIT, 5, width of i_hour / alarm hour
P_TIMER_BIT, 9, width of the internal second timer; must hold max(P_RING_SEC, P_SNOOZE_SEC)
P_RING_SEC, 60, seconds of ringing before auto-timeout
P_SNOOZE_SEC, 300, snooze length in seconds
P_MAX_SNOOZE, 3, max snoozes per alarm event (2-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_alarm_en  in  1  level; 1 = alarm enabled
i_alarm_set  in  1  1-cycle pulse: load i_alarm_hour/i_alarm_min
i_alarm_hour  in  P_HOUR_BIT  alarm hour to load, 0..23
i_alarm_min  in  P_MIN_BIT  alarm minute to load, 0..59
i_stop  in  1  1-cycle pulse: stop ringing/snooze
i_snooze  in  1  1-cycle pulse: request snooze
i_sec  in  P_SEC_BIT  live seconds
i_min  in  P_MIN_BIT  live minutes
i_hour  in  P_HOUR_BIT  live hours
o_ring  out  1  ringing indicator
o_alarm_hour  out  P_HOUR_BIT  stored alarm hour
o_alarm_min  out  P_MIN_BIT  stored alarm minute
o_state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE
o_snooze_num  out  2  snoozes used in the current event
o_missed  out  1  1-cycle pulse on ring auto-timeout
o_set_err  out  1  1-cycle pulse on out-of-range set

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock and reset ports are named clk and reset.
- Reset values: state IDLE, alarm time 00:00, timer 0, snooze_num 0, all outputs 0, sec_vld 0.
- Second tick: sec_d registers i_sec every cycle; sec_vld is set 1 cycle after reset.
  - sec_tick = sec_vld && (i_sec != sec_d), evaluated combinationally.
  - The first cycle after reset never generates a tick.
- Match: sec_tick && i_sec==0 && i_min==alarm_min && i_hour==alarm_hour. This fires exactly once per minute boundary.
- All outputs are registered. o_ring = (state==RINGING) and goes high the cycle after the match cycle.
- Set: on i_alarm_set, load the alarm registers only if hour<24 and min<60.
  - Otherwise the registers are kept and o_set_err pulses the next cycle.
  - A valid set while RINGING or SNOOZE cancels the event: go to ARMED with snooze_num=0.
- Priority per cycle: reset > !i_alarm_en > valid i_alarm_set > i_stop > i_snooze > timers/match.
- !i_alarm_en in any state -> IDLE; timer and snooze_num cleared.
- IDLE: i_alarm_en=1 -> ARMED. Match is ignored in IDLE.
- ARMED: match -> RINGING; timer=0, snooze_num=0.
- RINGING:
  - i_stop -> ARMED, snooze_num=0.
  - i_snooze with snooze_num<P_MAX_SNOOZE -> SNOOZE, snooze_num+1, timer=0.
  - i_snooze with snooze_num==P_MAX_SNOOZE is ignored and ringing continues.
  - Otherwise timer increments on each sec_tick. A sec_tick with timer==P_RING_SEC-1 -> ARMED, snooze_num=0, o_missed pulse.
- SNOOZE:
  - i_stop -> ARMED, snooze_num=0. i_snooze is ignored.
  - timer increments on each sec_tick. A sec_tick with timer==P_SNOOZE_SEC-1 -> RINGING, timer=0.
- Simultaneous i_stop and i_snooze: stop wins.
- Match while already RINGING/SNOOZE is ignored, including the next day's match.
- Time jumps (i_sec changing by more than 1) still count as one tick. Setting the watch backward never re-arms mid-event.
- Wrap: no arithmetic on time values; comparisons only. Timers never exceed their terminal count.

Decomposition:
- Shared package matbi_watch_pkg holds:
  - the state encoding constants (ST_IDLE=0, ST_ARMED=1, ST_RINGING=2, ST_SNOOZE=3);
  - the limits 24 and 60;
  - the default bit widths shared with the watch counters.
- One natural sub-module: matbi_sec_edge_det, containing sec_d, sec_vld and sec_tick. The FSM and timers stay in the top of this block.

Test Plan:
- Reset, then i_alarm_en=1 -> o_state=1 after 1 cycle. All other outputs 0, alarm time 00:00.
- Set 07:30, time steps 07:29:59 -> 07:30:00 -> o_ring=1 the cycle after the step. No ring on 07:30:01 or on a 07:31:00 step.
- Ringing, 60 sec_ticks with no input -> o_missed pulses once, o_ring=0, o_state=1.
- Ringing: snooze x3, each followed by 300 ticks -> ring resumes each time. A 4th snooze is ignored and o_snooze_num stays 3. i_stop -> ARMED, o_snooze_num=0.
- i_stop and i_snooze in the same cycle while ringing -> ARMED. Deassert i_alarm_en during SNOOZE -> IDLE next cycle, o_ring=0.
- Set hour=24 or min=60 -> o_set_err pulse, alarm registers unchanged. Valid set during RINGING -> ARMED with new time. Reset asserted mid-SNOOZE -> all reset values next cycle.

Source files
------------

// File: rtl/matbi_watch_pkg.sv
// Shared definitions for the watch family: default counter widths,
// time-of-day limits and the alarm controller state encoding.
package matbi_watch_pkg;

    // Default widths of the watch counter outputs.
    localparam int SEC_BIT  = 6;
    localparam int MIN_BIT  = 6;
    localparam int HOUR_BIT = 5;

    // Exclusive upper bounds of a valid time of day.
    localparam int HOUR_LIMIT = 24;
    localparam int MIN_LIMIT  = 60;

    // Alarm controller states; the encoding is visible on o_state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/matbi_sec_edge_det.sv
// Detects second boundaries by watching the live seconds value change.
// Any change counts as exactly one tick, so time jumps give one tick.
module matbi_sec_edge_det
    import matbi_watch_pkg::*;
#(
    parameter int P_SEC_BIT = SEC_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P_SEC_BIT-1:0] i_sec,
    output logic                 o_sec_tick
);

    logic [P_SEC_BIT-1:0] sec_d_reg;
    logic                 sec_vld_reg;

    // Delay the seconds value; sec_d is only trusted one cycle after reset.
    always_ff @(posedge clk) begin
        sec_d_reg <= i_sec;
        if (reset) begin
            sec_vld_reg <= 1'b0;
        end else begin
            sec_vld_reg <= 1'b1;
        end
    end

    assign o_sec_tick = sec_vld_reg && (i_sec != sec_d_reg);

endmodule

// File: rtl/matbi_alarm_ctrl.sv
// Alarm controller: stores an alarm time, rings on the exact minute
// boundary of a match, and handles stop, bounded snooze and ring timeout.
module matbi_alarm_ctrl
    import matbi_watch_pkg::*;
#(
    parameter int P_SEC_BIT    = SEC_BIT,
    parameter int P_MIN_BIT    = MIN_BIT,
    parameter int P_HOUR_BIT   = HOUR_BIT,
    parameter int P_TIMER_BIT  = 9,
    parameter int P_RING_SEC   = 60,
    parameter int P_SNOOZE_SEC = 300,
    parameter int P_MAX_SNOOZE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_alarm_en,
    input  logic                  i_alarm_set,
    input  logic [P_HOUR_BIT-1:0] i_alarm_hour,
    input  logic [P_MIN_BIT-1:0]  i_alarm_min,
    input  logic                  i_stop,
    input  logic                  i_snooze,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    output logic                  o_ring,
    output logic [P_HOUR_BIT-1:0] o_alarm_hour,
    output logic [P_MIN_BIT-1:0]  o_alarm_min,
    output logic [1:0]            o_state,
    output logic [1:0]            o_snooze_num,
    output logic                  o_missed,
    output logic                  o_set_err
);

    localparam logic [P_HOUR_BIT-1:0]  HOUR_MAX    = P_HOUR_BIT'(HOUR_LIMIT);
    localparam logic [P_MIN_BIT-1:0]   MIN_MAX     = P_MIN_BIT'(MIN_LIMIT);
    localparam logic [P_TIMER_BIT-1:0] RING_LAST   = P_TIMER_BIT'(P_RING_SEC - 1);
    localparam logic [P_TIMER_BIT-1:0] SNOOZE_LAST = P_TIMER_BIT'(P_SNOOZE_SEC - 1);
    localparam logic [P_TIMER_BIT-1:0] TIMER_ONE   = P_TIMER_BIT'(1);
    localparam logic [1:0]             SNOOZE_MAX  = 2'(P_MAX_SNOOZE);

    alarm_state_t            state_reg,      state_next;
    logic [P_TIMER_BIT-1:0]  timer_reg,      timer_next;
    logic [1:0]              snooze_num_reg, snooze_num_next;
    logic [P_HOUR_BIT-1:0]   alarm_hour_reg, alarm_hour_next;
    logic [P_MIN_BIT-1:0]    alarm_min_reg,  alarm_min_next;
    logic                    ring_reg;
    logic                    missed_reg,     missed_next;
    logic                    set_err_reg,    set_err_next;

    logic sec_tick;
    logic match;
    logic set_valid;

    matbi_sec_edge_det #(
        .P_SEC_BIT (P_SEC_BIT)
    ) u_sec_edge_det (
        .clk        (clk),
        .reset      (reset),
        .i_sec      (i_sec),
        .o_sec_tick (sec_tick)
    );

    // Minute boundary of the stored alarm time, seen once per boundary.
    assign match = sec_tick && (i_sec == '0) &&
                   (i_min == alarm_min_reg) && (i_hour == alarm_hour_reg);

    assign set_valid = i_alarm_set && (i_alarm_hour < HOUR_MAX) && (i_alarm_min < MIN_MAX);

    // Next-state logic in priority order: enable, set, stop, snooze, timers/match.
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        snooze_num_next = snooze_num_reg;
        alarm_hour_next = alarm_hour_reg;
        alarm_min_next  = alarm_min_reg;
        missed_next     = 1'b0;
        set_err_next    = i_alarm_set && !set_valid;

        if (set_valid) begin
            alarm_hour_next = i_alarm_hour;
            alarm_min_next  = i_alarm_min;
        end

        if (!i_alarm_en) begin
            state_next      = ST_IDLE;
            timer_next      = '0;
            snooze_num_next = '0;
        end else if (set_valid) begin
            // A new alarm time abandons any ringing/snoozing event.
            state_next      = ST_ARMED;
            timer_next      = '0;
            snooze_num_next = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match) begin
                        state_next      = ST_RINGING;
                        timer_next      = '0;
                        snooze_num_next = '0;
                    end
                end
                ST_RINGING: begin
                    if (i_stop) begin
                        state_next      = ST_ARMED;
                        timer_next      = '0;
                        snooze_num_next = '0;
                    end else if (i_snooze && (snooze_num_reg < SNOOZE_MAX)) begin
                        state_next      = ST_SNOOZE;
                        timer_next      = '0;
                        snooze_num_next = snooze_num_reg + 2'd1;
                    end else if (sec_tick) begin
                        if (timer_reg == RING_LAST) begin
                            state_next      = ST_ARMED;
                            timer_next      = '0;
                            snooze_num_next = '0;
                            missed_next     = 1'b1;
                        end else begin
                            timer_next = timer_reg + TIMER_ONE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (i_stop) begin
                        state_next      = ST_ARMED;
                        timer_next      = '0;
                        snooze_num_next = '0;
                    end else if (sec_tick) begin
                        if (timer_reg == SNOOZE_LAST) begin
                            state_next = ST_RINGING;
                            timer_next = '0;
                        end else begin
                            timer_next = timer_reg + TIMER_ONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, timers, alarm time and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            snooze_num_reg <= '0;
            alarm_hour_reg <= '0;
            alarm_min_reg  <= '0;
            ring_reg       <= 1'b0;
            missed_reg     <= 1'b0;
            set_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            snooze_num_reg <= snooze_num_next;
            alarm_hour_reg <= alarm_hour_next;
            alarm_min_reg  <= alarm_min_next;
            ring_reg       <= (state_next == ST_RINGING);
            missed_reg     <= missed_next;
            set_err_reg    <= set_err_next;
        end
    end

    assign o_ring       = ring_reg;
    assign o_alarm_hour = alarm_hour_reg;
    assign o_alarm_min  = alarm_min_reg;
    assign o_state      = state_reg;
    assign o_snooze_num = snooze_num_reg;
    assign o_missed     = missed_reg;
    assign o_set_err    = set_err_reg;

endmodule

// File: tb/tb_matbi_alarm_ctrl.sv
// Self-checking bench for matbi_alarm_ctrl: directed scenarios plus a
// randomized run, every cycle compared against a countdown-based model.
module tb_matbi_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_alarm_en;
    logic       i_alarm_set;
    logic [4:0] i_alarm_hour;
    logic [5:0] i_alarm_min;
    logic       i_stop;
    logic       i_snooze;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       o_ring;
    logic [4:0] o_alarm_hour;
    logic [5:0] o_alarm_min;
    logic [1:0] o_state;
    logic [1:0] o_snooze_num;
    logic       o_missed;
    logic       o_set_err;

    matbi_alarm_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_alarm_en   (i_alarm_en),
        .i_alarm_set  (i_alarm_set),
        .i_alarm_hour (i_alarm_hour),
        .i_alarm_min  (i_alarm_min),
        .i_stop       (i_stop),
        .i_snooze     (i_snooze),
        .i_sec        (i_sec),
        .i_min        (i_min),
        .i_hour       (i_hour),
        .o_ring       (o_ring),
        .o_alarm_hour (o_alarm_hour),
        .o_alarm_min  (o_alarm_min),
        .o_state      (o_state),
        .o_snooze_num (o_snooze_num),
        .o_missed     (o_missed),
        .o_set_err    (o_set_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: states as plain numbers, ring/snooze as countdowns.
    int m_state, m_ah, m_am, m_snz, m_ring_left, m_snz_left, m_prev_sec;
    bit m_have_prev, m_missed, m_set_err;
    int t_now;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick, match, valid;
        if (reset) begin
            m_state = 0; m_ah = 0; m_am = 0; m_snz = 0;
            m_ring_left = 0; m_snz_left = 0;
            m_missed = 0; m_set_err = 0;
            m_have_prev = 0;
            m_prev_sec = int'(i_sec);
            return;
        end
        tick        = m_have_prev && (int'(i_sec) != m_prev_sec);
        m_prev_sec  = int'(i_sec);
        m_have_prev = 1;
        match = tick && (int'(i_sec) == 0) && (int'(i_min) == m_am) && (int'(i_hour) == m_ah);
        valid = i_alarm_set && (int'(i_alarm_hour) < 24) && (int'(i_alarm_min) < 60);
        m_missed  = 0;
        m_set_err = i_alarm_set && !valid;
        if (valid) begin
            m_ah = int'(i_alarm_hour);
            m_am = int'(i_alarm_min);
        end
        if (!i_alarm_en) begin
            m_state = 0; m_snz = 0;
        end else if (valid) begin
            m_state = 1; m_snz = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (match) begin
                       m_state = 2; m_snz = 0; m_ring_left = 60;
                   end
                2: if (i_stop) begin
                       m_state = 1; m_snz = 0;
                   end else if (i_snooze && m_snz < 3) begin
                       m_state = 3; m_snz++; m_snz_left = 300;
                   end else if (tick) begin
                       m_ring_left--;
                       if (m_ring_left == 0) begin
                           m_state = 1; m_snz = 0; m_missed = 1;
                       end
                   end
                default: if (i_stop) begin
                       m_state = 1; m_snz = 0;
                   end else if (tick) begin
                       m_snz_left--;
                       if (m_snz_left == 0) begin
                           m_state = 2; m_ring_left = 60;
                       end
                   end
            endcase
        end
    endtask

    task automatic set_time(input int t);
        t_now  = t % 86400;
        i_hour = 5'(t_now / 3600);
        i_min  = 6'((t_now / 60) % 60);
        i_sec  = 6'(t_now % 60);
    endtask

    // One clock: update model from present inputs, clock, compare, drop pulses.
    task automatic cycle();
        logic [31:0] obs, exp;
        model_step();
        @(posedge clk);
        #1;
        obs = {13'd0, o_state, o_ring, o_snooze_num, o_missed, o_set_err, 1'b0, o_alarm_hour, o_alarm_min};
        exp = 32'((m_state << 17) | ((m_state == 2 ? 1 : 0) << 16) | (m_snz << 14) |
                  (int'(m_missed) << 13) | (int'(m_set_err) << 12) | (m_ah << 6) | m_am);
        check_val("cycle", obs, exp);
        i_alarm_set = 1'b0;
        i_stop      = 1'b0;
        i_snooze    = 1'b0;
    endtask

    // Advance live time by one second, then hold it for one extra cycle.
    task automatic step_sec();
        set_time(t_now + 1);
        cycle();
        cycle();
    endtask

    task automatic set_alarm(input int h, input int m);
        i_alarm_hour = 5'(h);
        i_alarm_min  = 6'(m);
        i_alarm_set  = 1'b1;
        cycle();
    endtask

    // Jump to one second before hh:mm:00, then step onto the boundary.
    task automatic ring_at(input int h, input int m);
        set_time(h * 3600 + m * 60 - 1);
        cycle();
        cycle();
        set_time(t_now + 1);
        cycle();
        check_val("ring_start", {31'd0, o_ring}, 32'd1);
    endtask

    int missed_cnt;

    initial begin
        reset = 1'b1; i_alarm_en = 1'b0; i_alarm_set = 1'b0;
        i_alarm_hour = '0; i_alarm_min = '0; i_stop = 1'b0; i_snooze = 1'b0;
        set_time(0);

        // Reset and arm
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check_val("rst_state", {30'd0, o_state}, 32'd0);
        check_val("rst_alarm", {21'd0, o_alarm_hour, o_alarm_min}, 32'd0);
        check_val("rst_flags", {28'd0, o_ring, o_snooze_num[0], o_missed, o_set_err}, 32'd0);
        i_alarm_en = 1'b1;
        cycle();
        check_val("arm_state", {30'd0, o_state}, 32'd1);
        $display("[tb] reset and arm done");

        // Exact-boundary ring at 07:30
        set_alarm(7, 30);
        check_val("alarm_0730", {21'd0, o_alarm_hour, o_alarm_min}, {21'd0, 5'd7, 6'd30});
        set_time(7 * 3600 + 29 * 60 + 58);
        cycle(); cycle();
        step_sec();
        check_val("no_ring_0729", {31'd0, o_ring}, 32'd0);
        set_time(t_now + 1);
        cycle();
        check_val("ring_0730", {31'd0, o_ring}, 32'd1);
        i_stop = 1'b1;
        cycle();
        check_val("stop_armed", {30'd0, o_state}, 32'd1);
        step_sec();
        check_val("no_ring_0730_01", {31'd0, o_ring}, 32'd0);
        set_time(7 * 3600 + 30 * 60 + 59);
        cycle();
        step_sec();
        check_val("no_ring_0731", {31'd0, o_ring}, 32'd0);
        $display("[tb] match at 07:30 done");

        // Auto-timeout after 60 ticks
        ring_at(7, 30);
        missed_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 59) check_val("ring_before_to", {31'd0, o_ring}, 32'd1);
            set_time(t_now + 1);
            cycle();
            if (o_missed) missed_cnt++;
            cycle();
            if (o_missed) missed_cnt++;
        end
        check_val("missed_once", 32'(missed_cnt), 32'd1);
        check_val("to_ring", {31'd0, o_ring}, 32'd0);
        check_val("to_state", {30'd0, o_state}, 32'd1);
        $display("[tb] ring timeout done");

        // Three snoozes, fourth ignored, then stop
        ring_at(7, 30);
        for (int k = 1; k <= 3; k++) begin
            i_snooze = 1'b1;
            cycle();
            check_val("snz_state", {30'd0, o_state}, 32'd3);
            check_val("snz_num", {30'd0, o_snooze_num}, 32'(k));
            for (int i = 0; i < 299; i++) step_sec();
            check_val("snz_still", {31'd0, o_ring}, 32'd0);
            step_sec();
            check_val("snz_resume", {31'd0, o_ring}, 32'd1);
        end
        i_snooze = 1'b1;
        cycle();
        check_val("snz4_state", {30'd0, o_state}, 32'd2);
        check_val("snz4_num", {30'd0, o_snooze_num}, 32'd3);
        i_stop = 1'b1;
        cycle();
        check_val("snz_stop_state", {30'd0, o_state}, 32'd1);
        check_val("snz_stop_num", {30'd0, o_snooze_num}, 32'd0);
        $display("[tb] snooze sequence done");

        // Stop and snooze together; disable during snooze
        ring_at(7, 30);
        i_stop = 1'b1; i_snooze = 1'b1;
        cycle();
        check_val("stop_wins", {30'd0, o_state}, 32'd1);
        ring_at(7, 30);
        i_snooze = 1'b1;
        cycle();
        step_sec();
        i_alarm_en = 1'b0;
        cycle();
        check_val("dis_state", {30'd0, o_state}, 32'd0);
        check_val("dis_ring", {31'd0, o_ring}, 32'd0);
        i_alarm_en = 1'b1;
        cycle();
        $display("[tb] stop+snooze and disable done");

        // Out-of-range sets, set while ringing, reset mid-snooze
        set_alarm(24, 10);
        check_val("err_h24", {31'd0, o_set_err}, 32'd1);
        check_val("err_h24_keep", {21'd0, o_alarm_hour, o_alarm_min}, {21'd0, 5'd7, 6'd30});
        cycle();
        check_val("err_pulse_end", {31'd0, o_set_err}, 32'd0);
        set_alarm(3, 60);
        check_val("err_m60", {31'd0, o_set_err}, 32'd1);
        check_val("err_m60_keep", {21'd0, o_alarm_hour, o_alarm_min}, {21'd0, 5'd7, 6'd30});
        ring_at(7, 30);
        set_alarm(8, 15);
        check_val("set_ring_state", {30'd0, o_state}, 32'd1);
        check_val("set_ring_time", {21'd0, o_alarm_hour, o_alarm_min}, {21'd0, 5'd8, 6'd15});
        ring_at(8, 15);
        i_snooze = 1'b1;
        cycle();
        step_sec();
        reset = 1'b1;
        cycle();
        check_val("rst_mid_state", {30'd0, o_state}, 32'd0);
        check_val("rst_mid_all", {19'd0, o_ring, o_snooze_num, o_missed, o_set_err, o_alarm_hour, o_alarm_min}, 32'd0);
        reset = 1'b0;
        cycle();
        $display("[tb] set errors and mid-event reset done");

        // Randomized run against the model
        for (int c = 0; c < 8000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset      = (r < 2);
            i_alarm_en = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 1) == 1) set_time(t_now + 1);
            if ($urandom_range(0, 199) == 0) set_time(int'($urandom_range(0, 86399)));
            if (i_alarm_en && $urandom_range(0, 299) == 0) begin
                i_alarm_hour = 5'(((t_now / 60 + 1) % 1440) / 60);
                i_alarm_min  = 6'((t_now / 60 + 1) % 60);
                i_alarm_set  = 1'b1;
            end else if (i_alarm_en && $urandom_range(0, 499) == 0) begin
                i_alarm_hour = 5'($urandom_range(0, 31));
                i_alarm_min  = 6'($urandom_range(0, 63));
                i_alarm_set  = 1'b1;
            end
            i_stop   = ($urandom_range(0, 199) == 0);
            i_snooze = ($urandom_range(0, 39) == 0);
            cycle();
            reset = 1'b0;
        end
        $display("[tb] random run done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
